// File: rtl/enigma_pkg.sv
// Enigma tables shared by the rotor core: rotor wirings I..V and their inverses,
// reflector B, turnover notches, and the core's FSM/direction encodings.
package enigma_pkg;

   localparam int NUM_WIRINGS = 5;

   typedef logic [4:0] tbl_t;

   // Forward wirings, rotors I..V: WIRING[r][entry contact] = exit contact.
   localparam tbl_t WIRING [NUM_WIRINGS][26] = '{
      '{4,10,12,5,11,6,3,16,21,25,13,19,14,22,24,7,23,20,18,15,0,8,1,17,2,9},
      '{0,9,3,10,18,8,17,20,23,1,11,7,22,19,12,2,16,6,25,13,15,24,5,21,14,4},
      '{1,3,5,7,9,11,2,15,17,19,23,21,25,13,24,4,8,22,6,0,10,12,20,18,16,14},
      '{4,18,14,21,15,25,9,0,24,16,20,8,17,7,23,11,13,5,19,6,10,3,2,12,22,1},
      '{21,25,1,17,6,8,19,24,20,15,18,3,13,7,11,23,0,22,12,9,16,14,5,4,2,10}
   };

   // Inverse wirings for the return path through the rotor stack.
   localparam tbl_t INV_WIRING [NUM_WIRINGS][26] = '{
      '{20,22,24,6,0,3,5,15,21,25,1,4,2,10,12,19,7,23,18,11,17,8,13,16,14,9},
      '{0,9,15,2,25,22,17,11,5,1,3,10,14,19,24,20,16,6,4,13,7,23,12,8,21,18},
      '{19,0,6,1,15,2,18,3,16,4,20,5,21,13,25,7,24,8,23,9,22,11,17,10,14,12},
      '{7,25,22,21,0,17,19,13,11,6,20,15,23,16,2,4,9,12,1,18,10,3,24,14,8,5},
      '{16,2,24,11,23,22,4,13,5,19,25,14,18,12,21,9,20,3,10,6,8,0,17,15,7,1}
   };

   // Reflector B (an involution, which is what makes the machine reciprocal).
   localparam tbl_t REFL_B [26] =
      '{24,17,20,7,16,18,11,3,15,23,13,6,14,10,12,8,4,1,5,25,2,22,21,9,0,19};

   // Position a rotor shows just before it carries its left neighbour: Q E V J Z.
   localparam tbl_t NOTCH [NUM_WIRINGS] = '{16, 4, 21, 9, 25};

   typedef enum logic [2:0] {
      ST_IDLE, ST_STEP, ST_FWD, ST_REFL, ST_BWD, ST_DONE
   } state_e;

   typedef enum logic {
      DIR_FWD = 1'b0,
      DIR_BWD = 1'b1
   } dir_e;

   // Unknown rotor selections fall back to rotor I rather than reading past the table.
   function automatic tbl_t notch_of(input logic [2:0] sel);
      return (int'(sel) < NUM_WIRINGS) ? NOTCH[sel] : NOTCH[0];
   endfunction

endpackage

// File: rtl/enigma_rotor_map.sv
// One rotor pass: shift the letter by the rotor position, look it up in the
// forward or inverse wiring, and shift back. Purely combinational.
module enigma_rotor_map
   import enigma_pkg::*;
#(
   parameter int ALPHA = 26,
   parameter int CW    = 5
) (
   input  logic [CW-1:0] char_i,
   input  logic [CW-1:0] pos_i,
   input  logic [2:0]    rotor_sel_i,
   input  dir_e          dir_i,
   output logic [CW-1:0] char_o
);

   localparam logic [CW:0] ALPHA_W = (CW+1)'(ALPHA);

   logic [CW:0]   sum;
   logic [CW-1:0] contact;
   logic [2:0]    sel;
   tbl_t          tbl_idx;
   tbl_t          wired;
   logic [CW-1:0] mapped;

   // Modular add on CW+1 bits with one conditional subtract, then modular subtract with one conditional add.
   always_comb begin
      sum     = {1'b0, char_i} + {1'b0, pos_i};
      contact = (sum >= ALPHA_W) ? CW'(sum - ALPHA_W) : sum[CW-1:0];
      sel     = (int'(rotor_sel_i) < NUM_WIRINGS) ? rotor_sel_i : 3'd0;
      tbl_idx = tbl_t'(contact);
      wired   = (dir_i == DIR_BWD) ? INV_WIRING[sel][tbl_idx] : WIRING[sel][tbl_idx];
      mapped  = CW'(wired);
      if (mapped >= pos_i) begin
         char_o = mapped - pos_i;
      end else begin
         char_o = CW'(({1'b0, mapped} + ALPHA_W) - {1'b0, pos_i});
      end
   end

endmodule

// File: rtl/enigma_rotor_core.sv
// Enigma cipher core: NUM_ROTORS rotors with double-step, reflector B and
// loadable start positions. One letter per transaction, one rotor pass per cycle
// through a single shared rotor_map instance.
//
// Handshakes: a letter is taken on a cycle where in_valid & in_ready; in_ready is
// high only in IDLE with no cfg_load. A result is presented with out_valid and held
// unchanged (out_char, out_err) until the cycle where out_valid & out_ready.
module enigma_rotor_core
   import enigma_pkg::*;
#(
   parameter int                      NUM_ROTORS = 3,
   parameter int                      ALPHA      = 26,
   parameter int                      CW         = 5,
   parameter logic [3*NUM_ROTORS-1:0] ROTOR_SEL  = (3*NUM_ROTORS)'(9'o210)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     cfg_load,
   input  logic [NUM_ROTORS*CW-1:0] cfg_pos,
   input  logic                     in_valid,
   input  logic [CW-1:0]            in_char,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [CW-1:0]            out_char,
   output logic                     out_err,
   input  logic                     out_ready,
   output logic [NUM_ROTORS*CW-1:0] pos
);

   localparam int            KW      = $clog2(NUM_ROTORS);
   localparam logic [KW-1:0] K_LAST  = KW'(NUM_ROTORS-1);
   localparam logic [CW:0]   ALPHA_W = (CW+1)'(ALPHA);

   state_e                state_q, state_d;
   logic [KW-1:0]         k_q, k_d;
   logic [CW-1:0]         c_q, c_d;
   logic                  err_q, err_d;
   logic [CW-1:0]         pos_q [NUM_ROTORS];
   logic [CW-1:0]         pos_d [NUM_ROTORS];
   logic [2:0]            sel_arr [NUM_ROTORS];
   logic [NUM_ROTORS-1:0] step_en;
   logic [CW-1:0]         map_char;
   dir_e                  dir;
   logic                  accept;
   logic                  bad_char;

   genvar g;
   for (g = 0; g < NUM_ROTORS; g++) begin : g_rotor
      assign sel_arr[g]      = ROTOR_SEL[3*g +: 3];
      assign pos[g*CW +: CW] = pos_q[g];
   end

   assign dir      = (state_q == ST_BWD) ? DIR_BWD : DIR_FWD;
   assign accept   = (state_q == ST_IDLE) && !cfg_load && in_valid;
   assign bad_char = ({1'b0, in_char} >= ALPHA_W);

   enigma_rotor_map #(
      .ALPHA (ALPHA),
      .CW    (CW)
   ) u_map (
      .char_i      (c_q),
      .pos_i       (pos_q[k_q]),
      .rotor_sel_i (sel_arr[k_q]),
      .dir_i       (dir),
      .char_o      (map_char)
   );

   // State, rotor counter, letter, error flag and rotor positions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         c_q     <= '0;
         err_q   <= 1'b0;
         for (int i = 0; i < NUM_ROTORS; i++) pos_q[i] <= '0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         c_q     <= c_d;
         err_q   <= err_d;
         for (int i = 0; i < NUM_ROTORS; i++) pos_q[i] <= pos_d[i];
      end
   end

   // Next state: walk rotors 0..N-1, reflect, walk back N-1..0; bad letters skip straight to DONE.
   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      case (state_q)
         ST_IDLE: if (accept) state_d = bad_char ? ST_DONE : ST_STEP;
         ST_STEP: begin
            state_d = ST_FWD;
            k_d     = '0;
         end
         ST_FWD: begin
            if (k_q == K_LAST) state_d = ST_REFL;
            else               k_d     = k_q + 1'b1;
         end
         ST_REFL: begin
            state_d = ST_BWD;
            k_d     = K_LAST;
         end
         ST_BWD: begin
            if (k_q == '0) state_d = ST_DONE;
            else           k_d     = k_q - 1'b1;
         end
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Which rotors advance this keypress; every decision looks at pre-step positions only.
   always_comb begin
      step_en    = '0;
      step_en[0] = 1'b1;
      for (int i = 1; i < NUM_ROTORS; i++) begin
         step_en[i] = (pos_q[i-1] == CW'(notch_of(sel_arr[i-1])))
                   || ((i <= NUM_ROTORS-2) && (pos_q[i] == CW'(notch_of(sel_arr[i]))));
      end
   end

   // Datapath: load positions, capture the letter, step rotors, and run each substitution.
   always_comb begin
      c_d   = c_q;
      err_d = err_q;
      for (int i = 0; i < NUM_ROTORS; i++) pos_d[i] = pos_q[i];
      case (state_q)
         ST_IDLE: begin
            if (cfg_load) begin
               for (int i = 0; i < NUM_ROTORS; i++) begin
                  pos_d[i] = ({1'b0, cfg_pos[i*CW +: CW]} >= ALPHA_W) ? '0 : cfg_pos[i*CW +: CW];
               end
            end else if (in_valid) begin
               c_d   = in_char;
               err_d = bad_char;
            end
         end
         ST_STEP: begin
            for (int i = 0; i < NUM_ROTORS; i++) begin
               if (step_en[i]) pos_d[i] = (pos_q[i] == CW'(ALPHA-1)) ? '0 : pos_q[i] + 1'b1;
            end
         end
         ST_FWD, ST_BWD: c_d = map_char;
         ST_REFL:        c_d = CW'(REFL_B[tbl_t'(c_q)]);
         default: ;
      endcase
   end

   // Handshake and result outputs decoded from state and registers.
   always_comb begin
      in_ready  = (state_q == ST_IDLE) && !cfg_load;
      out_valid = (state_q == ST_DONE);
      out_char  = c_q;
      out_err   = err_q;
   end

endmodule

// File: tb/tb_enigma_rotor_core.sv
// Bench for enigma_rotor_core with rotors I (left), II (middle), III (right).
// Stimulus pushes the hand-computed result into exp_q; an independent monitor
// pops and compares whenever the core presents out_valid.
module tb_enigma_rotor_core;

   localparam int N  = 3;
   localparam int A  = 26;
   localparam int CW = 5;
   localparam int W  = CW + 1;
   localparam logic [3*N-1:0] SEL = {3'd0, 3'd1, 3'd2};

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic            cfg_load = 1'b0;
   logic [N*CW-1:0] cfg_pos = '0;
   logic            in_valid = 1'b0;
   logic [CW-1:0]   in_char = '0;
   logic            in_ready;
   logic            out_valid;
   logic [CW-1:0]   out_char;
   logic            out_err;
   logic            out_ready = 1'b1;
   logic [N*CW-1:0] pos;

   int n_vec = 0;
   int n_err = 0;
   int stall_req = 0;
   logic [W-1:0] exp_q[$];

   // Clock.
   always #5 clk = ~clk;

   enigma_rotor_core #(
      .NUM_ROTORS (N),
      .ALPHA      (A),
      .CW         (CW),
      .ROTOR_SEL  (SEL)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cfg_load  (cfg_load),
      .cfg_pos   (cfg_pos),
      .in_valid  (in_valid),
      .in_char   (in_char),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_char  (out_char),
      .out_err   (out_err),
      .out_ready (out_ready),
      .pos       (pos)
   );

   function automatic logic [N*CW-1:0] p3(input int l, input int m, input int r);
      return {CW'(l), CW'(m), CW'(r)};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic send(input int ch, input int exp_ch, input bit exp_err, input bit push);
      int t = 0;
      @(negedge clk);
      while (!in_ready && t < 300) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
      end else begin
         if (push) exp_q.push_back({exp_err, CW'(exp_ch)});
         in_valid = 1'b1;
         in_char  = CW'(ch);
         @(negedge clk);
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int t = 0;
      do begin
         @(negedge clk);
         t++;
      end while (!(exp_q.size() == 0 && in_ready) && t < 300);
      if (t >= 300) begin
         n_vec++;
         n_err++;
         $display("FAIL idle_timeout: %0d results outstanding, in_ready %0d", exp_q.size(), in_ready);
      end
   endtask

   task automatic load(input logic [N*CW-1:0] p);
      @(negedge clk);
      cfg_load = 1'b1;
      cfg_pos  = p;
      @(negedge clk);
      cfg_load = 1'b0;
   endtask

   // Monitor / scoreboard: compare each presented result, and hold-check it during a requested stall.
   initial begin : monitor
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL unexpected_output: got char %0d err %0d, expected none", out_char, out_err);
            end else begin
               e = exp_q.pop_front();
               check("out_char", out_char, e[CW-1:0]);
               check("out_err", out_err, e[CW]);
               if (!out_ready) begin
                  repeat (stall_req) begin
                     @(negedge clk);
                     check("stall_out_valid", out_valid, 1);
                     check("stall_out_char", out_char, e[CW-1:0]);
                     check("stall_in_ready", in_ready, 0);
                  end
                  stall_req = 0;
                  out_ready = 1'b1;
               end
            end
         end
      end
   end

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   // Stimulus.
   initial begin
      int t1[5]  = '{1, 3, 25, 6, 14};
      int pt[5]  = '{7, 4, 11, 11, 14};
      int ct[5]  = '{8, 11, 1, 3, 0};
      int t;

      // Reset values.
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_pos", pos, 0);
      check("reset_out_valid", out_valid, 0);
      check("reset_out_char", out_char, 0);
      check("reset_out_err", out_err, 0);
      check("reset_in_ready", in_ready, 1);
      rst_n = 1'b1;

      // AAAAA from AAA -> BDZGO.
      for (int i = 0; i < 5; i++) send(0, t1[i], 1'b0, 1'b1);
      wait_idle();
      check("pos_after_bdzgo", pos, p3(0, 0, 5));

      // Out-of-range letter: error result one cycle after accept, rotors untouched.
      send(26, 26, 1'b1, 1'b1);
      check("err_latency_valid", out_valid, 1);
      check("err_latency_flag", out_err, 1);
      wait_idle();
      check("pos_after_err", pos, p3(0, 0, 5));
      send(0, 22, 1'b0, 1'b1);
      wait_idle();
      check("pos_after_err_next", pos, p3(0, 0, 6));

      // Double-step from ADU.
      load(p3(0, 3, 20));
      check("pos_load_adu", pos, p3(0, 3, 20));
      send(0, 4, 1'b0, 1'b1);
      wait_idle();
      check("pos_adv", pos, p3(0, 3, 21));
      send(0, 16, 1'b0, 1'b1);
      wait_idle();
      check("pos_aew", pos, p3(0, 4, 22));
      send(0, 8, 1'b0, 1'b1);
      wait_idle();
      check("pos_bfx", pos, p3(1, 5, 23));

      // Reciprocity: HELLO -> ILBDA -> HELLO.
      load(p3(0, 0, 0));
      for (int i = 0; i < 5; i++) send(pt[i], ct[i], 1'b0, 1'b1);
      wait_idle();
      check("pos_after_hello", pos, p3(0, 0, 5));
      load(p3(0, 0, 0));
      check("pos_reload_aaa", pos, 0);
      for (int i = 0; i < 5; i++) send(ct[i], pt[i], 1'b0, 1'b1);
      wait_idle();

      // Consumer stall for 5 cycles with stray input pulses.
      load(p3(0, 0, 0));
      stall_req = 5;
      out_ready = 1'b0;
      send(0, 1, 1'b0, 1'b1);
      t = 0;
      while (!out_valid && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL stall_wait: out_valid not seen within %0d cycles", t);
      end
      repeat (2) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_char  = CW'(9);
         @(negedge clk);
         in_valid = 1'b0;
      end
      wait_idle();
      check("pos_after_stall", pos, p3(0, 0, 1));

      // Reset in the middle of a forward pass.
      send(0, 0, 1'b0, 1'b0);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrun_reset_pos", pos, 0);
      check("midrun_reset_out_valid", out_valid, 0);
      check("midrun_reset_in_ready", in_ready, 1);
      @(negedge clk);
      rst_n = 1'b1;

      // cfg_load with in_valid: load only, out-of-range field loads as 0.
      @(negedge clk);
      cfg_load = 1'b1;
      cfg_pos  = p3(0, 31, 4);
      in_valid = 1'b1;
      in_char  = '0;
      #1;
      check("load_in_ready", in_ready, 0);
      @(negedge clk);
      cfg_load = 1'b0;
      in_valid = 1'b0;
      check("pos_load_clamped", pos, p3(0, 0, 4));
      repeat (4) begin
         @(negedge clk);
         check("load_no_output", out_valid, 0);
      end
      send(0, 14, 1'b0, 1'b1);
      wait_idle();
      check("pos_after_load_letter", pos, p3(0, 0, 5));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
